// File: rtl/encoder_value_ctrl_pkg.sv
// Shared types and constants for the encoder value controller.
// Holds rate FSM encodings and default clock/timing figures.
package encoder_value_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SLOW = 2'd1,
    ST_FAST = 2'd2
  } rate_st_e;

  localparam int FAST_WIN_10MS = 120_000;
  localparam int CLK_HZ        = 12_000_000;

  // Bits needed to hold 0..n inclusive
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/encoder_value_ctrl_if.sv
// Detent/load inputs and value/status outputs of the controller.
// master drives detents and loads, slave is the controller.
interface encoder_value_ctrl_if #(
  parameter int WIDTH = 8
);

  logic             l_pulse;
  logic             r_pulse;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] value;
  logic             changed;
  logic             dir;
  logic             fast;

  modport master (
    output l_pulse, r_pulse, load, load_val,
    input  value, changed, dir, fast
  );

  modport slave (
    input  l_pulse, r_pulse, load, load_val,
    output value, changed, dir, fast
  );

endinterface

// File: rtl/encoder_value_ctrl_rate_detect.sv
// Rotation-rate detector: detent interval timer, streak counter
// and IDLE/SLOW/FAST state machine.
module enc_rate_detect
  import encoder_value_ctrl_pkg::*;
#(
  parameter int FAST_WIN = FAST_WIN_10MS,
  parameter int FAST_CNT = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic det_valid,
  input  logic det_dir,
  input  logic clr,
  output logic use_fast,
  output logic fast
);

  localparam int TW = cnt_w(FAST_WIN);
  localparam int SW = cnt_w(FAST_CNT);
  localparam logic [TW-1:0] L_WIN = TW'(FAST_WIN);
  localparam logic [SW-1:0] L_CNT = SW'(FAST_CNT);

  logic [TW-1:0] r_timer;
  logic [SW-1:0] r_streak;
  logic          r_dir;
  rate_st_e      r_state;
  logic [SW-1:0] w_streak;
  logic          w_hit;

  // Streak the current detent would produce
  always_comb begin
    w_streak = SW'(1);
    if (det_dir == r_dir && r_timer < L_WIN) begin
      w_streak = (r_streak >= L_CNT) ? L_CNT
                                     : r_streak + SW'(1);
    end
  end

  assign w_hit    = (w_streak == L_CNT);
  assign use_fast = det_valid & w_hit;
  assign fast     = (r_state == ST_FAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timer  <= L_WIN;
      r_streak <= '0;
      r_dir    <= 1'b0;
      r_state  <= ST_IDLE;
    end else if (clr) begin
      r_timer  <= L_WIN;
      r_streak <= '0;
      r_state  <= ST_IDLE;
    end else if (det_valid) begin
      r_timer  <= '0;
      r_streak <= w_streak;
      r_dir    <= det_dir;
      r_state  <= w_hit ? ST_FAST : ST_SLOW;
    end else if (r_timer != L_WIN) begin
      r_timer <= r_timer + TW'(1);
      // Window closes: rotation considered stopped
      if (r_timer == L_WIN - TW'(1)) begin
        r_streak <= '0;
        r_state  <= ST_IDLE;
      end
    end
  end

endmodule

// File: rtl/encoder_value_ctrl.sv
// Bounded parameter value driven by encoder detents, with
// rate acceleration, saturate/wrap limits and clamped load.
module encoder_value_ctrl
  import encoder_value_ctrl_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MIN_VAL   = 0,
  parameter int MAX_VAL   = 100,
  parameter int INIT_VAL  = 50,
  parameter int WRAP      = 0,
  parameter int FAST_WIN  = FAST_WIN_10MS,
  parameter int FAST_CNT  = 3,
  parameter int STEP_SLOW = 1,
  parameter int STEP_FAST = 10
) (
  input logic                clk,
  input logic                rst,
  encoder_value_ctrl_if.slave bus
);

  localparam int VW = WIDTH + 1;
  localparam logic [WIDTH:0] L_MIN = VW'(MIN_VAL);
  localparam logic [WIDTH:0] L_MAX = VW'(MAX_VAL);
  localparam logic [WIDTH:0] L_RNG = VW'(MAX_VAL - MIN_VAL + 1);
  localparam logic [WIDTH:0] L_SF  = VW'(STEP_FAST);
  localparam logic [WIDTH:0] L_SS  = VW'(STEP_SLOW);
  localparam logic [WIDTH-1:0] L_INIT = WIDTH'(INIT_VAL);

  logic             w_det;
  logic             w_use_fast;
  logic [WIDTH:0]   w_cur;
  logic [WIDTH:0]   w_step;
  logic [WIDTH:0]   w_up;
  logic [WIDTH:0]   w_dn;
  logic [WIDTH:0]   w_ld;
  logic [WIDTH:0]   w_next;
  logic [WIDTH-1:0] r_value;
  logic             r_changed;
  logic             r_dir;

  // A load swallows any detent in the same cycle
  assign w_det = (bus.l_pulse ^ bus.r_pulse) & ~bus.load;
  assign w_cur = {1'b0, r_value};

  always_comb begin
    w_step = w_use_fast ? L_SF : L_SS;
    w_up   = w_cur + w_step;
    if (w_up > L_MAX) begin
      w_up = (WRAP != 0) ? w_up - L_RNG : L_MAX;
    end
    w_dn = w_cur - w_step;
    if (w_cur < L_MIN + w_step) begin
      w_dn = (WRAP != 0) ? w_cur + L_RNG - w_step : L_MIN;
    end
    w_ld = {1'b0, bus.load_val};
    if (w_ld < L_MIN) begin
      w_ld = L_MIN;
    end else if (w_ld > L_MAX) begin
      w_ld = L_MAX;
    end
    w_next = w_cur;
    unique case (1'b1)
      bus.load: w_next = w_ld;
      w_det:    w_next = bus.r_pulse ? w_up : w_dn;
      default:  w_next = w_cur;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_value   <= L_INIT;
      r_changed <= 1'b0;
      r_dir     <= 1'b0;
    end else begin
      r_value   <= w_next[WIDTH-1:0];
      r_changed <= (w_next != w_cur);
      if (w_det) begin
        r_dir <= bus.r_pulse;
      end
    end
  end

  enc_rate_detect #(
    .FAST_WIN (FAST_WIN),
    .FAST_CNT (FAST_CNT)
  ) u_rate (
    .clk       (clk),
    .rst       (rst),
    .det_valid (w_det),
    .det_dir   (bus.r_pulse),
    .clr       (bus.load),
    .use_fast  (w_use_fast),
    .fast      (bus.fast)
  );

  assign bus.value   = r_value;
  assign bus.changed = r_changed;
  assign bus.dir     = r_dir;

endmodule

// File: tb/tb_encoder_value_ctrl.sv
// Scoreboard bench: saturating and wrapping controllers driven by
// shared random detent/load/reset traffic against a reference model.
module tb_encoder_value_ctrl;

  localparam int FW   = 40;
  localparam int FC   = 3;
  localparam int SF   = 10;
  localparam int SS   = 1;
  localparam int MINV = 0;
  localparam int MAXV = 100;
  localparam int INIT = 50;

  typedef struct {
    int v;
    bit ch;
    bit dir;
    bit fast;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  encoder_value_ctrl_if #(.WIDTH(8)) ifa ();
  encoder_value_ctrl_if #(.WIDTH(8)) ifb ();

  encoder_value_ctrl #(
    .WIDTH(8), .MIN_VAL(MINV), .MAX_VAL(MAXV), .INIT_VAL(INIT),
    .WRAP(0), .FAST_WIN(FW), .FAST_CNT(FC),
    .STEP_SLOW(SS), .STEP_FAST(SF)
  ) u_sat (
    .clk(clk), .rst(rst), .bus(ifa.slave)
  );

  encoder_value_ctrl #(
    .WIDTH(8), .MIN_VAL(MINV), .MAX_VAL(MAXV), .INIT_VAL(INIT),
    .WRAP(1), .FAST_WIN(FW), .FAST_CNT(FC),
    .STEP_SLOW(SS), .STEP_FAST(SF)
  ) u_wrap (
    .clk(clk), .rst(rst), .bus(ifb.slave)
  );

  exp_t qa[$];
  exp_t qb[$];
  int nchk  = 0;
  int npass = 0;

  // Reference state: value, last direction, streak length and
  // the edge index of the last accepted detent.
  int mv[2];
  int mdir[2];
  int mstr[2];
  int mlast[2];
  int medge = 0;
  int cwrap[2] = '{0, 1};
  int prev_dir = 1;

  task automatic chk(input string nm, input exp_t e, input int v,
                     input bit ch, input bit dr, input bit fs);
    nchk++;
    if (v == e.v && ch == e.ch && dr == e.dir && fs == e.fast) begin
      npass++;
    end else begin
      $display("FAIL %s t=%0t: got value=%0d changed=%0b dir=%0b fast=%0b, expected value=%0d changed=%0b dir=%0b fast=%0b",
               nm, $time, v, ch, dr, fs, e.v, e.ch, e.dir, e.fast);
    end
  endtask

  task automatic model_edge(input bit l, input bit r, input bit ld,
                            input int lv, input bit rs);
    for (int k = 0; k < 2; k++) begin
      exp_t e;
      int nv;
      int step;
      nv = mv[k];
      if (rs) begin
        nv = INIT;
        mdir[k] = 0;
        mstr[k] = 0;
        mlast[k] = medge - 100_000;
      end else if (ld) begin
        nv = (lv < MINV) ? MINV : (lv > MAXV) ? MAXV : lv;
        mstr[k] = 0;
        mlast[k] = medge - 100_000;
      end else if (l != r) begin
        if (int'(r) == mdir[k] && medge - mlast[k] <= FW) begin
          mstr[k] = (mstr[k] >= FC) ? FC : mstr[k] + 1;
        end else begin
          mstr[k] = 1;
        end
        step = (mstr[k] == FC) ? SF : SS;
        if (r) begin
          nv = mv[k] + step;
          if (nv > MAXV) nv = cwrap[k] != 0 ? nv - (MAXV - MINV + 1) : MAXV;
        end else begin
          nv = mv[k] - step;
          if (nv < MINV) nv = cwrap[k] != 0 ? nv + (MAXV - MINV + 1) : MINV;
        end
        mdir[k] = int'(r);
        mlast[k] = medge;
      end else if (medge - mlast[k] >= FW) begin
        mstr[k] = 0;
      end
      e.ch   = !rs && (nv != mv[k]);
      mv[k]  = nv;
      e.v    = nv;
      e.dir  = mdir[k] != 0;
      e.fast = (mstr[k] == FC);
      if (k == 0) qa.push_back(e);
      else        qb.push_back(e);
    end
    medge++;
  endtask

  task automatic drive(input bit l, input bit r, input bit ld,
                       input int lv, input bit rs);
    rst = rs;
    ifa.l_pulse = l;  ifb.l_pulse = l;
    ifa.r_pulse = r;  ifb.r_pulse = r;
    ifa.load = ld;    ifb.load = ld;
    ifa.load_val = 8'(lv);
    ifb.load_val = 8'(lv);
    model_edge(l, r, ld, lv, rs);
  endtask

  task automatic cyc(input bit l, input bit r, input bit ld,
                     input int lv, input bit rs);
    @(negedge clk);
    drive(l, r, ld, lv, rs);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 0, 0);
  endtask

  task automatic burst(input bit r, input int n, input int gap);
    repeat (n) begin
      cyc(!r, r, 0, 0, 0);
      idle(gap);
    end
  endtask

  // Async reset must take effect before any clock edge
  task automatic do_reset();
    exp_t z;
    bit l;
    bit r;
    z.v = INIT; z.ch = 0; z.dir = 0; z.fast = 0;
    @(negedge clk);
    l = 1'($urandom);
    r = 1'($urandom);
    drive(l, r, 0, 0, 1);
    #1;
    chk("sat_async_rst", z, int'(ifa.value), ifa.changed, ifa.dir, ifa.fast);
    chk("wrap_async_rst", z, int'(ifb.value), ifb.changed, ifb.dir, ifb.fast);
    repeat (2) cyc(1'($urandom), 1'($urandom), 0, 0, 1);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (qa.size() > 0) begin
        e = qa.pop_front();
        chk("sat", e, int'(ifa.value), ifa.changed, ifa.dir, ifa.fast);
      end
      if (qb.size() > 0) begin
        e = qb.pop_front();
        chk("wrap", e, int'(ifb.value), ifb.changed, ifb.dir, ifb.fast);
      end
    end
  end

  initial begin
    int p;
    bit d;
    for (int k = 0; k < 2; k++) begin
      mv[k] = INIT; mdir[k] = 0; mstr[k] = 0; mlast[k] = -100_000;
    end
    ifa.l_pulse = 0; ifa.r_pulse = 0; ifa.load = 0; ifa.load_val = '0;
    ifb.l_pulse = 0; ifb.r_pulse = 0; ifb.load = 0; ifb.load_val = '0;
    repeat (3) cyc(1'($urandom), 1'($urandom), 0, 0, 1);
    idle(3);

    // slow detents only
    burst(1, 5, 60);
    // acceleration: 51, 52, 62, 72 then expiry
    cyc(0, 0, 1, 50, 0);
    idle(5);
    burst(1, 4, 9);
    idle(FW + 10);
    // direction reversal out of fast mode
    cyc(0, 0, 1, 50, 0);
    burst(1, 3, 4);
    burst(0, 1, 60);
    // saturation at max, then both pulses together
    cyc(0, 0, 1, 99, 0);
    burst(1, 3, 2);
    cyc(1, 1, 0, 0, 0);
    idle(60);
    // wrap at top with coarse step, slow wrap at bottom
    cyc(0, 0, 1, 98, 0);
    burst(1, 4, 1);
    cyc(0, 0, 1, 0, 0);
    idle(3);
    burst(0, 2, 60);
    // load clamps and beats a same-cycle detent
    burst(1, 2, 3);
    cyc(0, 1, 1, 200, 0);
    idle(5);
    cyc(1, 0, 1, 0, 0);
    idle(5);
    // reset mid-streak
    burst(1, 3, 2);
    do_reset();
    idle(5);

    repeat (400) begin
      p = $urandom_range(0, 99);
      d = ($urandom_range(0, 99) < 80) ? prev_dir[0] : ~prev_dir[0];
      if (p < 5) begin
        cyc(1'($urandom), 1'($urandom), 1, $urandom_range(0, 255), 0);
      end else if (p < 8) begin
        cyc(1, 1, 0, 0, 0);
      end else if (p < 10) begin
        do_reset();
      end else if (p < 75) begin
        cyc(!d, d, 0, 0, 0);
        prev_dir = int'(d);
      end else begin
        idle(1);
      end
      if ($urandom_range(0, 99) < 75) idle($urandom_range(0, 12));
      else idle($urandom_range(30, 70));
    end

    cyc(0, 0, 0, 0, 0);
    @(posedge clk);
    #2;
    nchk++;
    if (qa.size() == 0 && qb.size() == 0) begin
      npass++;
    end else begin
      $display("FAIL drain: got %0d/%0d entries left, expected 0/0",
               qa.size(), qb.size());
    end
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

// File: doc/encoder_value_ctrl.md
Name: encoder_value_ctrl

Overview:
Consumes the single-cycle left/right detent pulses from the rotary-encoder driver and maintains a bounded parameter value (volume, frequency index, menu position). Adds rotation-rate acceleration: several same-direction detents in quick succession switch to a coarse step. Supports saturate-at-limit or wrap-around, plus a synchronous load. Sits between the encoder driver and display/DDS consumers, all on the 12 MHz system clock.

Parameters:
WIDTH, 8, width of value and load_val.
MIN_VAL, 0, lowest legal value.
MAX_VAL, 100, highest legal value; MIN_VAL < MAX_VAL < 2^WIDTH.
INIT_VAL, 50, value after reset; must lie in range.
WRAP, 0, 0 = saturate at limits, 1 = wrap around.
FAST_WIN, 120_000, max cycles between detents to count as fast (10 ms at 12 MHz).
FAST_CNT, 3, consecutive fast same-direction detents needed to enter fast mode.
STEP_SLOW, 1, normal step.
STEP_FAST, 10, accelerated step; STEP_FAST <= MAX_VAL-MIN_VAL+1.

Ports:
clk  in  1  system clock, 12 MHz
rst  in  1  asynchronous, active-high reset
l_pulse  in  1  one-cycle left-rotation pulse, decrements value
r_pulse  in  1  one-cycle right-rotation pulse, increments value
load  in  1  synchronous load strobe
load_val  in  WIDTH  value to load, clamped into [MIN_VAL, MAX_VAL]
value  out  WIDTH  current value, registered
changed  out  1  one-cycle strobe when value actually changes
dir  out  1  direction of last accepted detent: 1 = right/up, 0 = left/down
fast  out  1  high while in FAST state

Behaviour:
- Reset (async, rst=1): value=INIT_VAL, changed=0, dir=0, fast=0, state=IDLE, streak=0, interval timer=FAST_WIN (saturated).
- Accepted detent: exactly one of l_pulse/r_pulse high. Both high in the same cycle: ignored completely, with no state, timer or value change.
- Interval timer: cleared to 0 on each accepted detent, otherwise increments and saturates at FAST_WIN.
- Streak: on an accepted detent, if the direction equals dir and timer < FAST_WIN, streak = min(streak+1, FAST_CNT); otherwise streak = 1.
- FSM states:
  - IDLE: no recent detent. An accepted detent goes to SLOW.
  - SLOW: a detent that raises streak to FAST_CNT goes to FAST.
  - FAST: a direction change goes to SLOW with streak=1.
  - Any state: timer reaching FAST_WIN goes to IDLE with streak=0.
- fast = (state == FAST), registered.
- Step selection uses the updated streak. The detent that makes streak reach FAST_CNT already uses STEP_FAST; otherwise STEP_SLOW.
- Arithmetic is done in WIDTH+1 bits, with no intermediate overflow.
  - Up: if value+step > MAX_VAL, result is MAX_VAL (WRAP=0) or value+step-(MAX_VAL-MIN_VAL+1) (WRAP=1).
  - Down: if value < MIN_VAL+step, result is MIN_VAL (WRAP=0) or value-step+(MAX_VAL-MIN_VAL+1) (WRAP=1).
- Latency: value, dir and changed update on the clock edge after the cycle the pulse is sampled high (1 cycle).
- changed=1 only if the new value differs from the old one. A saturated detent at a limit gives changed=0, but dir, streak and timer still update.
- load priority: load wins over a same-cycle detent; that detent is dropped entirely.
  - Load result: value = clamp(load_val). changed = 1 if this differs from the old value.
  - Load effects on rate logic: state=IDLE, streak=0, timer=FAST_WIN, dir unchanged.
- Reset mid-rotation: all state returns to reset values immediately; pulses while rst=1 are ignored.

Decomposition:
- Shared package/header holds:
  - FSM state encodings: IDLE=2'd0, SLOW=2'd1, FAST=2'd2.
  - Default timing constants FAST_WIN_10MS=120_000, CLK_HZ=12_000_000.
- One natural sub-module, enc_rate_detect: interval timer, streak counter and FSM.
  - Inputs: clk, rst, det_valid, det_dir, clr.
  - Outputs: use_fast, fast.
- The top level keeps the value arithmetic and load path.

Test Plan:
- Reset then 5 r_pulse spaced 200_000 cycles apart: value 50→55; fast stays 0; changed pulses 5 times, 1 cycle after each pulse; dir=1.
- 4 r_pulse spaced 1_000 cycles apart from 50: steps 1,1,10,10 → 51, 52, 62, 72; fast rises on the 3rd detent. After 120_000 idle cycles fast=0 and state=IDLE.
- Fast streak of 3 right, then 1 left within 1_000 cycles: left detent uses step 1, fast drops to 0, value decrements by 1, dir=0.
- WRAP=0, value=99, 3 fast right detents: 100, 100, 100; changed only on the first. Then l_pulse and r_pulse high in the same cycle: no change at all.
- WRAP=1, MIN=0, MAX=100, value=98, fast right step 10: value becomes 7. Slow left from 0: value becomes 100.
- load=1 with load_val=200 and r_pulse in the same cycle: value=100 (clamped), changed=1, detent ignored, fast=0. Assert rst mid-streak: value=50 immediately, all outputs at reset values.
